// File: rtl/pong_game_sequencer_pkg.sv
// Shared types and constants for the Pong game controller and its helpers.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_POINT = 3'd4,
    ST_OVER  = 3'd5
  } game_state_t;

  // USB HID usage codes
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_P     = 8'h13;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_DOWN  = 8'h51;

  localparam int DEF_WIN_SCORE    = 7;
  localparam int DEF_SERVE_FRAMES = 90;
  localparam int DEF_POINT_FRAMES = 60;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pong_game_sequencer_frame_tick_sync.sv
// Brings the VGA vertical sync into the Clk domain and emits a one-cycle
// pulse per rising edge, three Clk edges after the edge arrives.
module frame_tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync1_q, sync2_q, sync3_q, tick_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      tick_q  <= sync2_q & ~sync3_q;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/pong_game_sequencer.sv
// Pong game controller: sequences serve, play, pause, point hold and game
// over, keeps both scores and drives the ball module's motion controls.
module pong_game_sequencer
  import pong_pkg::*;
#(
  parameter int         WIN_SCORE    = DEF_WIN_SCORE,
  parameter int         SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int         POINT_FRAMES = DEF_POINT_FRAMES,
  parameter logic [7:0] KEY_START    = KEY_SPACE,
  parameter logic [7:0] KEY_PAUSE    = KEY_P
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       miss_l,
  input  logic       miss_r,
  output logic       ball_run,
  output logic       ball_center,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state_dbg
);

  localparam int CNT_W = $clog2(max_int(SERVE_FRAMES, POINT_FRAMES) + 1);
  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] POINT_LOAD = CNT_W'(POINT_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [3:0]       WIN_Q      = 4'(WIN_SCORE);

  logic frame_tick;

  frame_tick_sync u_frame_tick_sync (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  game_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       score_l_q, score_l_d, score_r_q, score_r_d;
  logic             serve_dir_q, serve_dir_d;
  logic [7:0]       key_prev_q;

  logic       ball_run_q, ball_center_q, serve_dir_out_q;
  logic       game_over_q, winner_q;
  logic [3:0] score_l_out_q, score_r_out_q;
  logic [2:0] state_dbg_q;

  logic start_ev, pause_ev;

  // A held key produces a single event on its first cycle
  assign start_ev = (keycode == KEY_START) && (key_prev_q != KEY_START);
  assign pause_ev = (keycode == KEY_PAUSE) && (key_prev_q != KEY_PAUSE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    serve_dir_d = serve_dir_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ev) begin
          state_d     = ST_SERVE;
          cnt_d       = SERVE_LOAD;
          serve_dir_d = 1'b0;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (cnt_q != CNT_ZERO) cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE)  state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // A scoring tick takes precedence over a coincident pause press
        if (frame_tick && miss_l) begin
          score_r_d   = score_r_q + 4'd1;
          serve_dir_d = 1'b0;
          cnt_d       = POINT_LOAD;
          state_d     = ST_POINT;
        end else if (frame_tick && miss_r) begin
          score_l_d   = score_l_q + 4'd1;
          serve_dir_d = 1'b1;
          cnt_d       = POINT_LOAD;
          state_d     = ST_POINT;
        end else if (pause_ev) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause_ev) state_d = ST_PLAY;
      end
      ST_POINT: begin
        if (frame_tick) begin
          if (cnt_q != CNT_ZERO) cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            if ((score_l_q == WIN_Q) || (score_r_q == WIN_Q)) begin
              state_d = ST_OVER;
            end else begin
              state_d = ST_SERVE;
              cnt_d   = SERVE_LOAD;
            end
          end
        end
      end
      ST_OVER: begin
        if (start_ev) begin
          state_d   = ST_IDLE;
          score_l_d = 4'd0;
          score_r_d = 4'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      serve_dir_q <= 1'b0;
      key_prev_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      serve_dir_q <= serve_dir_d;
      key_prev_q  <= keycode;
    end
  end

  // Output register stage: every output follows the game state by one Clk
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ball_run_q      <= 1'b0;
      ball_center_q   <= 1'b1;
      serve_dir_out_q <= 1'b0;
      score_l_out_q   <= 4'd0;
      score_r_out_q   <= 4'd0;
      game_over_q     <= 1'b0;
      winner_q        <= 1'b0;
      state_dbg_q     <= 3'd0;
    end else begin
      ball_run_q      <= (state_q == ST_PLAY);
      ball_center_q   <= (state_q inside {ST_IDLE, ST_SERVE, ST_OVER});
      serve_dir_out_q <= serve_dir_q;
      score_l_out_q   <= score_l_q;
      score_r_out_q   <= score_r_q;
      game_over_q     <= (state_q == ST_OVER);
      winner_q        <= (state_q == ST_OVER) && (score_r_q == WIN_Q);
      state_dbg_q     <= state_q;
    end
  end

  assign ball_run    = ball_run_q;
  assign ball_center = ball_center_q;
  assign serve_dir   = serve_dir_out_q;
  assign score_l     = score_l_out_q;
  assign score_r     = score_r_out_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;
  assign state_dbg   = state_dbg_q;

endmodule

// File: doc/pong_game_sequencer.md
Name: pong_game_sequencer

Overview:
- Top-level game controller for the Pong datapath.
- Sequences the ball/paddle engine through idle, serve countdown, play, pause, point-scored hold and game-over.
- Owns both 4-bit scores and decides the winner.
- Sits between the USB keycode register and the ball module: gates ball motion, forces ball recentre, drives serve direction and the HEX score digits.

Parameters:
- WIN_SCORE, 7: points needed to win; legal range 1..15.
- SERVE_FRAMES, 90: frames of recentred hold before ball release.
- POINT_FRAMES, 60: frames of frozen hold after a point.
- KEY_START, 8'h2C: HID keycode (space) that starts or restarts a game.
- KEY_PAUSE, 8'h13: HID keycode ('P') that toggles pause.

Ports:
- Clk  in  1  50 MHz system clock (MAX10_CLK1_50).
- Reset_n  in  1  synchronous, active-low reset.
- frame_clk  in  1  VGA_VS, asynchronous to Clk.
- keycode  in  8  current USB keycode; 0 means no key pressed.
- miss_l  in  1  level: ball has passed the left edge (right player's point).
- miss_r  in  1  level: ball has passed the right edge (left player's point).
- ball_run  out  1  ball may move this frame.
- ball_center  out  1  hold ball at screen centre.
- serve_dir  out  1  0 = serve toward left, 1 = serve toward right.
- score_l  out  4  left player score.
- score_r  out  4  right player score.
- game_over  out  1  high in the OVER state.
- winner  out  1  0 = left won, 1 = right won; valid while game_over=1.
- state_dbg  out  3  encoded current state, for LEDR.

Behaviour:
- Clocking and reset:
  - All logic runs on Clk.
  - Reset_n=0 sampled on a Clk edge resets everything, including mid-countdown or mid-play: state=IDLE, scores=0, counter=0, serve_dir=0, winner=0, ball_run=0, ball_center=1, game_over=0.
- Frame tick:
  - frame_clk passes through a 2-flop synchroniser, then rising-edge detection.
  - Result: frame_tick, a one-Clk pulse, 3 Clk after the VS rising edge.
- Key edges:
  - keycode is registered as key_prev.
  - start_ev = (keycode==KEY_START) && (key_prev!=KEY_START); pause_ev is formed the same way.
  - A held key fires exactly once.
- All outputs are registered: they change 1 Clk after the state transition.
- Frame counter: width $clog2(max(SERVE_FRAMES, POINT_FRAMES)+1); it decrements only on frame_tick.
- IDLE:
  - ball_center=1, ball_run=0.
  - start_ev -> SERVE, counter=SERVE_FRAMES, serve_dir=0.
- SERVE:
  - ball_center=1, ball_run=0.
  - On a frame_tick with counter==1 -> PLAY.
  - pause_ev is ignored.
- PLAY:
  - ball_run=1, ball_center=0.
  - miss_l/miss_r are sampled only on frame_tick:
    - miss_l=1: score_r+1, serve_dir=0 (serve toward the player who conceded), -> POINT, counter=POINT_FRAMES.
    - miss_r=1 (miss_l=0): score_l+1, serve_dir=1, -> POINT.
    - Both high on the same tick: miss_l has priority; exactly one point is awarded.
  - pause_ev -> PAUSE. If pause_ev and a scoring tick coincide, scoring wins and the pause is dropped.
- PAUSE:
  - ball_run=0, ball_center=0 (ball frozen in place).
  - pause_ev -> PLAY.
  - miss inputs and start_ev are ignored.
- POINT:
  - ball_run=0, ball_center=0.
  - On a frame_tick with counter==1: if score_l==WIN_SCORE or score_r==WIN_SCORE -> OVER; otherwise -> SERVE with counter=SERVE_FRAMES.
- OVER:
  - game_over=1; winner = (score_r==WIN_SCORE); ball_center=1.
  - Scores hold their final values.
  - start_ev -> IDLE, scores cleared in the same cycle.
- Score arithmetic: 4-bit. Scores never exceed WIN_SCORE because scoring only occurs in PLAY and OVER is entered before any further play.
- state_dbg encoding: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, POINT=4, OVER=5.

Decomposition:
- Package pong_pkg holds:
  - game_state_t enum (encoding as above).
  - HID key constants: KEY_SPACE, KEY_P, KEY_W, KEY_S, KEY_UP, KEY_DOWN.
  - Default frame counts.
- Sub-module frame_tick_sync: 2-flop synchroniser plus rising-edge pulse generator. It is reused by any Clk-domain block that needs frame timing.

Test Plan:
- Reset_n=0 for 2 Clk during PLAY with score_l=3 -> next cycle state_dbg=0, scores 0/0, ball_center=1, ball_run=0.
- keycode=8'h2C held 200 Clk in IDLE -> one transition to SERVE; after exactly 90 frame_ticks ball_run=1 and state_dbg=2.
- In PLAY, assert miss_r, then frame_tick -> score_l=1, serve_dir=1, state_dbg=4; after 60 ticks -> SERVE with ball_center=1.
- miss_l and miss_r both high on one tick -> score_r+1 only, score_l unchanged.
- 'P' pressed in PLAY -> PAUSE; miss_l pulsed over 5 ticks -> no score change; 'P' pressed again -> PLAY.
- Drive score_r to 6, then miss_l -> score_r=7; after POINT hold -> game_over=1, winner=1; space pressed -> IDLE, scores 0/0.
